pc_fetch_ctrl: RTL and testbench

//  Program-counter register and fetch sequencer for the 32-bit core. Drives pc into the

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch controller.
//   pc_state_t : fetch sequencer states (BOOT, FETCH, HOLD)
//   STEP       : byte increment the external adder applies to pc
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pc_state_t;

  localparam int unsigned STEP = 4;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer.
// The pc + STEP and branch-target adders live outside this block; it only
// holds the pc, sequences imem fetch requests and queues redirects.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   pc_seq         pc + STEP from the external adder
//   branch_target  redirect address, qualified by branch_taken
//   branch_taken   single-cycle redirect request
//   stall          downstream cannot take a new instruction
//   imem_ready     imem accepts the current request this cycle
//   imem_req       fetch request valid (registered, high only in FETCH)
//   pc             current fetch address
//   fetch_cnt      accepted-fetch counter, wraps
//   misaligned     sticky misaligned-redirect flag
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirects trap into
// HOLD instead of being applied; without it misaligned is tied low).
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     N          = 32,
  parameter logic [N-1:0]    RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pc_seq,
  input  logic [N-1:0] branch_target,
  input  logic         branch_taken,
  input  logic         stall,
  input  logic         imem_ready,
  output logic         imem_req,
  output logic [N-1:0] pc,
  output logic [N-1:0] fetch_cnt,
  output logic         misaligned
);

  pc_state_t    state;
  logic         pend_vld;
  logic [N-1:0] pend_addr;

  logic         accept;
  logic         redirect;
  logic [N-1:0] redirect_addr;
  logic [N-1:0] next_pc;
  logic         bad_redirect;
  logic         trapped;

  // A live branch beats a queued one; otherwise fall through to pc + STEP.
  assign accept        = (state == FETCH) & imem_ready & ~stall;
  assign redirect      = branch_taken | pend_vld;
  assign redirect_addr = branch_taken ? branch_target : pend_addr;
  assign next_pc       = redirect ? redirect_addr : pc_seq;

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign bad_redirect = redirect & (redirect_addr[1:0] != 2'b00);
  assign trapped      = misaligned_q;
  assign misaligned   = misaligned_q;

  // Sticky trap flag; once set the sequencer never leaves HOLD until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (accept && bad_redirect) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign bad_redirect = 1'b0;
  assign trapped      = 1'b0;
  assign misaligned   = 1'b0;
`endif

  // Sequencer, pc, fetch counter and redirect queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BOOT;
      imem_req  <= 1'b0;
      pc        <= RESET_ADDR;
      fetch_cnt <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else begin
      // Any branch not consumed by an accept is queued; latest wins.
      if (branch_taken && !accept) begin
        pend_vld  <= 1'b1;
        pend_addr <= branch_target;
      end

      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (accept) begin
            if (bad_redirect) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              pc        <= next_pc;
              pend_vld  <= 1'b0;
              fetch_cnt <= fetch_cnt + N'(1);
            end
          end else if (imem_ready && stall) begin
            state    <= HOLD;
            imem_req <= 1'b0;
          end
          // !imem_ready: request and address stay put while pending.
        end

        HOLD: begin
          if (!stall && !trapped) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
// Models the external adder as pc + 4; all expected values are hand-computed.
// Build with PC_MISALIGN_TRAP_EN defined to exercise the trap behaviour.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_seq;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] fetch_cnt;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // External pc + STEP adder.
  assign pc_seq = pc + 32'd4;

  pc_fetch_ctrl #(.N(32), .RESET_ADDR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_seq        (pc_seq),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc            (pc),
    .fetch_cnt     (fetch_cnt),
    .misaligned    (misaligned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                         input logic [31:0] e_cnt);
    chk({tag, ".pc"},  pc,                e_pc);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
    chk({tag, ".cnt"}, fetch_cnt,         e_cnt);
  endtask

  initial begin
    rst_n = 1'b0; branch_target = '0; branch_taken = 1'b0;
    stall = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 32'd0);
    chk("reset.mis", {31'd0, misaligned}, 32'd0);

    // 1: boot bubble then sequential fetch
    rst_n = 1'b1;
    chk("boot.req", {31'd0, imem_req}, 32'd0);
    tick(); chk_all("seq0", 32'h0, 1'b1, 32'd0);
    tick(); chk_all("seq1", 32'h4, 1'b1, 32'd1);
    tick(); chk_all("seq2", 32'h8, 1'b1, 32'd2);

    // 2: imem not ready holds pc/req
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("wait", 32'h8, 1'b1, 32'd2);
    end
    imem_ready = 1'b1;
    tick(); chk_all("wait_done", 32'hC, 1'b1, 32'd3);

    // 3: two queued branches, latest wins
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    tick(); chk_all("pend1", 32'hC, 1'b1, 32'd3);
    branch_target = 32'h200;
    tick(); chk_all("pend2", 32'hC, 1'b1, 32'd3);
    branch_taken = 1'b0; imem_ready = 1'b1;
    tick(); chk_all("pend_apply", 32'h200, 1'b1, 32'd4);
    tick(); chk_all("pend_clear", 32'h204, 1'b1, 32'd5);

    // 4: zero-bubble redirect at accept, then stall into HOLD
    branch_taken = 1'b1; branch_target = 32'h10;
    tick(); chk_all("live_br", 32'h10, 1'b1, 32'd6);
    branch_taken = 1'b0; stall = 1'b1;
    tick(); chk_all("hold0", 32'h10, 1'b0, 32'd6);
    tick(); chk_all("hold1", 32'h10, 1'b0, 32'd6);
    stall = 1'b0;
    tick(); chk_all("unhold", 32'h10, 1'b1, 32'd6);
    tick(); chk_all("unhold_acc", 32'h14, 1'b1, 32'd7);

    // Branch during HOLD is queued and applied at the next accept
    stall = 1'b1;
    tick(); chk_all("hold2", 32'h14, 1'b0, 32'd7);
    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); chk_all("hold_br", 32'h14, 1'b0, 32'd7);
    branch_taken = 1'b0; stall = 1'b0;
    tick(); chk_all("hold_exit", 32'h14, 1'b1, 32'd7);
    tick(); chk_all("hold_pend", 32'h40, 1'b1, 32'd8);

    // Live branch beats a pending one at accept
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    tick(); chk_all("pend3", 32'h40, 1'b1, 32'd8);
    imem_ready = 1'b1; branch_target = 32'h90;
    tick(); chk_all("live_wins", 32'h90, 1'b1, 32'd9);
    branch_taken = 1'b0;
    tick(); chk_all("live_clr", 32'h94, 1'b1, 32'd10);

    // 5: pc wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick(); chk_all("to_top", 32'hFFFF_FFFC, 1'b1, 32'd11);
    branch_taken = 1'b0;
    tick(); chk_all("wrap", 32'h0, 1'b1, 32'd12);
    chk("wrap.mis", {31'd0, misaligned}, 32'd0);

    // Reset mid-transaction drops the pending redirect
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_taken = 1'b0; rst_n = 1'b0;
    tick(); chk_all("rst_mid", 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1; imem_ready = 1'b1;
    tick(); chk_all("rst_boot", 32'h0, 1'b1, 32'd0);
    tick(); chk_all("rst_nopend", 32'h4, 1'b1, 32'd1);

    // 6: misaligned redirect at accept
    branch_taken = 1'b1; branch_target = 32'h102;
    tick();
    branch_taken = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk_all("trap", 32'h4, 1'b0, 32'd1);
    chk("trap.mis", {31'd0, misaligned}, 32'd1);
    tick(); tick();
    chk_all("trap_stuck", 32'h4, 1'b0, 32'd1);
    chk("trap_stuck.mis", {31'd0, misaligned}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("trap_rst.mis", {31'd0, misaligned}, 32'd0);
    chk_all("trap_rst", 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;
`else
    chk_all("unaligned", 32'h102, 1'b1, 32'd2);
    chk("unaligned.mis", {31'd0, misaligned}, 32'd0);
    tick(); chk_all("unaligned_seq", 32'h106, 1'b1, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
